// File: rtl/uart_bram_loader_if.sv
// BRAM write port and frame status bundle driven by uart_bram_loader.
interface uart_bram_loader_if #(
  parameter int AW = 14,
  parameter int DW = 48
);
  logic [AW-1:0] bram_addr_out;
  logic [DW-1:0] bram_din_out;
  logic          left_we_out;
  logic          right_we_out;
  logic          busy_out;
  logic          frame_done_out;
  logic          error_out;

  modport master (
    output bram_addr_out, bram_din_out, left_we_out, right_we_out,
           busy_out, frame_done_out, error_out
  );
  modport slave (
    input  bram_addr_out, bram_din_out, left_we_out, right_we_out,
           busy_out, frame_done_out, error_out
  );
endinterface

// File: rtl/uart_bram_loader.sv
// 8N1 UART receiver that packs bytes into words and writes the left/right frame BRAMs.
// Build option LOADER_TIMEOUT_EN adds an inter-byte timeout that aborts a stalled frame.
module uart_bram_loader #(
  parameter int         CLK_FREQ     = 100000000,
  parameter int         BAUD_RATE    = 3000000,
  parameter int         WORD_BYTES   = 6,
  parameter int         BRAM_DEPTH   = 12800,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 1000000
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               uart_rxd,
  uart_bram_loader_if.master bus
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int AW  = (BRAM_DEPTH > 1) ? $clog2(BRAM_DEPTH) : 1;
  localparam int DW  = 8 * WORD_BYTES;
  localparam int BW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int CW  = $clog2(CPB + 1);

  localparam logic [CW-1:0] BIT_END   = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_BITS  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [2:0] F_HUNT = 3'd0;
  localparam logic [2:0] F_SEL  = 3'd1;
  localparam logic [2:0] F_DATA = 3'd2;
  localparam logic [2:0] F_WR   = 3'd3;
  localparam logic [2:0] F_DONE = 3'd4;

  // Reset asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [2:0]    rx_st;
  logic          rx_s1, rx_s2, rx_d;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          byte_valid, rx_err;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_st      <= RX_IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_d       <= 1'b1;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      rx_s1      <= uart_rxd;
      rx_s2      <= rx_s1;
      rx_d       <= rx_s2;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
      rx_cnt     <= rx_cnt + 1'b1;
      case (rx_st)
        RX_IDLE: if (rx_d && !rx_s2) begin
          rx_st  <= RX_START;
          rx_cnt <= '0;
        end
        // Mid-start re-check rejects short low glitches.
        RX_START: if (rx_cnt == HALF_END) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s2 ? RX_IDLE : RX_BITS;
        end
        RX_BITS: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_st <= RX_STOP;
        end
        RX_STOP: if (rx_cnt == BIT_END) begin
          rx_cnt <= '0;
          if (rx_s2) byte_valid <= 1'b1;
          else       rx_err     <= 1'b1;
          rx_st <= RX_WAIT;
        end
        RX_WAIT: if (rx_s2) rx_st <= RX_IDLE;
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  logic [2:0]    f_st;
  logic          right_sel;
  logic [BW-1:0] byte_cnt;
  logic [AW-1:0] word_cnt;
  logic [DW-1:0] shreg, word_next;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;
  logic          left_we_q, right_we_q, busy_q, done_q, err_q;
  logic          timeout;

  always_comb begin
    word_next = shreg;
    word_next[8*byte_cnt +: 8] = rx_sh;
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_cnt;

  // Idle gap counter, only meaningful while a frame is open.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                                               to_cnt <= '0;
    else if (byte_valid || f_st == F_HUNT || f_st == F_DONE)  to_cnt <= '0;
    else if (!timeout)                                        to_cnt <= to_cnt + 1'b1;
  end
  assign timeout = (to_cnt == TW'(TIMEOUT_CLKS));
`else
  assign timeout = (TIMEOUT_CLKS < 0);
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      f_st       <= F_HUNT;
      right_sel  <= 1'b0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      left_we_q  <= 1'b0;
      right_we_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      left_we_q  <= 1'b0;
      right_we_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (f_st)
        F_HUNT: begin
          if (rx_err) err_q <= 1'b1;
          else if (byte_valid && rx_sh == SYNC_BYTE) f_st <= F_SEL;
        end
        F_SEL: begin
          if (rx_err || timeout) begin
            err_q <= 1'b1;
            f_st  <= F_HUNT;
          end else if (byte_valid) begin
            if (rx_sh == 8'h00 || rx_sh == 8'h01) begin
              right_sel <= rx_sh[0];
              busy_q    <= 1'b1;
              word_cnt  <= '0;
              byte_cnt  <= '0;
              f_st      <= F_DATA;
            end else begin
              err_q <= 1'b1;
              f_st  <= F_HUNT;
            end
          end
        end
        F_DATA: begin
          if (rx_err || timeout) begin
            err_q  <= 1'b1;
            busy_q <= 1'b0;
            f_st   <= F_HUNT;
          end else if (byte_valid) begin
            shreg <= word_next;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt   <= '0;
              din_q      <= word_next;
              addr_q     <= word_cnt;
              left_we_q  <= !right_sel;
              right_we_q <= right_sel;
              f_st       <= F_WR;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        F_WR: begin
          if (word_cnt == LAST_ADDR) f_st <= F_DONE;
          else begin
            word_cnt <= word_cnt + 1'b1;
            f_st     <= F_DATA;
          end
        end
        F_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          f_st   <= F_HUNT;
        end
        default: f_st <= F_HUNT;
      endcase
    end
  end

  assign bus.bram_addr_out  = addr_q;
  assign bus.bram_din_out   = din_q;
  assign bus.left_we_out    = left_we_q;
  assign bus.right_we_out   = right_we_q;
  assign bus.busy_out       = busy_q;
  assign bus.frame_done_out = done_q;
  assign bus.error_out      = err_q;
endmodule
